// File: rtl/spi_master_mc.sv
`default_nettype none
// ============================================================================
// Module : spi_master_mc
// Brief  : Fully synchronous multi-select SPI master clocked by sys_clock only,
//          runtime SCLK divider, all four modes, selectable bit order.
//          Optional macro SPI_LOOPBACK_EN adds the loopback input.
// Rev    : 1.0
// ============================================================================
module spi_master_mc #(
    parameter int DATA_W = 18,
    parameter int NUM_SS = 4,
    parameter int SS_W   = 2,
    parameter int DIV_W  = 8
) (
    input  logic              sys_clock,
    input  logic              reset_n,
    input  logic              tx_enable,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] data_in,
    input  logic [SS_W-1:0]   ss_sel,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic [1:0]        spi_mode,
    input  logic              lsb_first,
`ifdef SPI_LOOPBACK_EN
    input  logic              loopback,
`endif
    input  logic              miso,
    output logic [NUM_SS-1:0] ss_n,
    output logic              mosi,
    output logic              sclk,
    output logic [DATA_W-1:0] master_out,
    output logic              mrx_data_valid,
    output logic              tx_error
);

    localparam int                EDGE_W    = $clog2(2*DATA_W+1);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2*DATA_W-1);
    localparam logic [EDGE_W-1:0] EDGE_TERM = EDGE_W'(2*DATA_W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_XFER  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t              state_q;
    logic [DIV_W-1:0]    half_q;
    logic [DIV_W-1:0]    div_cnt_q;
    logic [EDGE_W-1:0]   edge_cnt_q;
    logic                cpha_q;
    logic                lsb_q;
    logic [DATA_W-1:0]   tx_sh_q;
    logic [DATA_W-1:0]   rx_sh_q;
    logic [NUM_SS-1:0]   ss_n_q;
    logic                mosi_q;
    logic                sclk_q;
    logic [DATA_W-1:0]   master_out_q;
    logic                valid_q;
    logic                err_q;

    logic                div_tick_d;
    logic                sel_ok_d;
    logic                lead_d;
    logic                last_d;
    logic                sample_d;
    logic                shift_d;
    logic                rx_bit_d;
    logic [DIV_W-1:0]    half_d;
    logic [DATA_W-1:0]   tx_next_d;
    logic [NUM_SS-1:0]   ss_dec_d;

    assign div_tick_d = (div_cnt_q == half_q - DIV_W'(1));
    assign sel_ok_d   = (32'(ss_sel) < 32'(NUM_SS));
    assign half_d     = (clk_div == '0) ? DIV_W'(1) : clk_div;

    // edge_cnt_q holds edges already produced, so an even count means the
    // upcoming edge is odd-numbered, i.e. a leading edge.
    assign lead_d   = ~edge_cnt_q[0];
    assign last_d   = (edge_cnt_q == LAST_EDGE);
    assign sample_d = cpha_q ? ~lead_d : lead_d;
    assign shift_d  = cpha_q ? (lead_d && (edge_cnt_q != '0)) : (~lead_d && ~last_d);

    assign tx_next_d = lsb_q ? (tx_sh_q >> 1) : (tx_sh_q << 1);

`ifdef SPI_LOOPBACK_EN
    logic lpbk_q;
    assign rx_bit_d = lpbk_q ? mosi_q : miso;
`else
    assign rx_bit_d = miso;
`endif

    always_comb begin
        ss_dec_d = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            if (32'(ss_sel) == 32'(i)) ss_dec_d[i] = 1'b0;
        end
    end

    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            half_q       <= '0;
            div_cnt_q    <= '0;
            edge_cnt_q   <= '0;
            cpha_q       <= 1'b0;
            lsb_q        <= 1'b0;
`ifdef SPI_LOOPBACK_EN
            lpbk_q       <= 1'b0;
`endif
            tx_sh_q      <= '0;
            rx_sh_q      <= '0;
            ss_n_q       <= '1;
            mosi_q       <= 1'b1;
            sclk_q       <= 1'b0;
            master_out_q <= '1;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    sclk_q     <= spi_mode[1];
                    mosi_q     <= 1'b1;
                    div_cnt_q  <= '0;
                    edge_cnt_q <= '0;
                    if (tx_enable) begin
                        if (sel_ok_d) begin
                            state_q <= S_SETUP;
                            half_q  <= half_d;
                            cpha_q  <= spi_mode[0];
                            lsb_q   <= lsb_first;
`ifdef SPI_LOOPBACK_EN
                            lpbk_q  <= loopback;
`endif
                            tx_sh_q <= data_in;
                            rx_sh_q <= '0;
                            ss_n_q  <= ss_dec_d;
                            mosi_q  <= lsb_first ? data_in[0] : data_in[DATA_W-1];
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_SETUP: begin
                    if (div_tick_d) begin
                        div_cnt_q <= '0;
                        state_q   <= S_XFER;
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_W'(1);
                    end
                end
                S_XFER: begin
                    if (div_tick_d) begin
                        div_cnt_q <= '0;
                        sclk_q    <= ~sclk_q;
                        if (edge_cnt_q != EDGE_TERM) edge_cnt_q <= edge_cnt_q + EDGE_W'(1);
                        // Received bits land so master_out uses data_in's bit order.
                        if (sample_d) begin
                            rx_sh_q <= lsb_q ? {rx_bit_d, rx_sh_q[DATA_W-1:1]}
                                             : {rx_sh_q[DATA_W-2:0], rx_bit_d};
                        end
                        if (shift_d) begin
                            tx_sh_q <= tx_next_d;
                            mosi_q  <= lsb_q ? tx_next_d[0] : tx_next_d[DATA_W-1];
                        end
                        if (last_d) state_q <= S_HOLD;
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_W'(1);
                    end
                end
                S_HOLD: begin
                    if (div_tick_d) begin
                        div_cnt_q    <= '0;
                        edge_cnt_q   <= '0;
                        state_q      <= S_IDLE;
                        ss_n_q       <= '1;
                        mosi_q       <= 1'b1;
                        master_out_q <= rx_sh_q;
                        valid_q      <= 1'b1;
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_ready       = (state_q == S_IDLE);
    assign ss_n           = ss_n_q;
    assign mosi           = mosi_q;
    assign sclk           = sclk_q;
    assign master_out     = master_out_q;
    assign mrx_data_valid = valid_q;
    assign tx_error       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_mc.sv
`default_nettype none
// ============================================================================
// Module : tb_spi_master_mc
// Brief  : Scoreboard bench for spi_master_mc with a behavioural SPI slave.
// Rev    : 1.0
// ============================================================================
module tb_spi_master_mc;

    localparam int N   = 18;
    localparam int NSS = 4;
    localparam int SSW = 3;
    localparam int DW  = 8;

    logic            sys_clock = 1'b0;
    logic            reset_n   = 1'b0;
    logic            tx_enable = 1'b0;
    logic            tx_ready;
    logic [N-1:0]    data_in   = '0;
    logic [SSW-1:0]  ss_sel    = '0;
    logic [DW-1:0]   clk_div   = 8'd1;
    logic [1:0]      spi_mode  = 2'd0;
    logic            lsb_first = 1'b0;
    logic            miso;
    logic [NSS-1:0]  ss_n;
    logic            mosi;
    logic            sclk;
    logic [N-1:0]    master_out;
    logic            mrx_data_valid;
    logic            tx_error;
`ifdef SPI_LOOPBACK_EN
    logic            loopback  = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int vcount = 0;

    // Slave model state
    logic [N-1:0]   s_word      = '0;
    logic [N-1:0]   s_cap       = '0;
    logic [1:0]     s_mode      = 2'd0;
    logic           s_lsb       = 1'b0;
    logic           s_echo      = 1'b0;
    logic           s_force0    = 1'b0;
    logic           s_miso      = 1'b1;
    logic           s_prev_sel  = 1'b0;
    logic           s_prev_sclk = 1'b0;
    logic           s_ss_bad    = 1'b0;
    logic [NSS-1:0] s_ss_seen   = '1;
    int             s_edges     = 0;
    int             s_rises     = 0;
    int             s_ncap      = 0;

    typedef struct {
        logic [N-1:0]   exp_out;
        logic [N-1:0]   exp_mosi;
        int             exp_cyc;
        logic [NSS-1:0] exp_ss;
    } sb_t;

    sb_t sb[$];
    sb_t e;

    assign miso = s_force0 ? 1'b0 : (s_echo ? mosi : s_miso);

    spi_master_mc #(
        .DATA_W (N),
        .NUM_SS (NSS),
        .SS_W   (SSW),
        .DIV_W  (DW)
    ) dut (
        .sys_clock      (sys_clock),
        .reset_n        (reset_n),
        .tx_enable      (tx_enable),
        .tx_ready       (tx_ready),
        .data_in        (data_in),
        .ss_sel         (ss_sel),
        .clk_div        (clk_div),
        .spi_mode       (spi_mode),
        .lsb_first      (lsb_first),
`ifdef SPI_LOOPBACK_EN
        .loopback       (loopback),
`endif
        .miso           (miso),
        .ss_n           (ss_n),
        .mosi           (mosi),
        .sclk           (sclk),
        .master_out     (master_out),
        .mrx_data_valid (mrx_data_valid),
        .tx_error       (tx_error)
    );

    always #5 sys_clock = ~sys_clock;
    always @(posedge sys_clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Slave: word position chosen from the SCLK edge count, mosi captured on
    // the edges where a slave of that mode samples.
    always @(negedge sys_clock) begin : slave
        int   idx;
        logic sel;
        sel = (ss_n != '1);
        if (sel && !s_prev_sel) begin
            s_edges = 0; s_rises = 0; s_ncap = 0; s_cap = '0;
            s_ss_seen = ss_n; s_ss_bad = 1'b0; s_prev_sclk = sclk;
        end
        if (sel) begin
            if (ss_n != s_ss_seen) s_ss_bad = 1'b1;
            if (sclk != s_prev_sclk) begin
                s_edges++;
                if (sclk) s_rises++;
                if (((s_edges % 2) == 1) == (s_mode[0] == 1'b0) && s_ncap < N) begin
                    s_cap[s_lsb ? s_ncap : N-1-s_ncap] = mosi;
                    s_ncap++;
                end
            end
            s_prev_sclk = sclk;
            if (s_mode[0]) idx = (s_edges == 0) ? 0 : (s_edges - 1) / 2;
            else           idx = s_edges / 2;
            if (idx > N-1) idx = N-1;
            s_miso = s_word[s_lsb ? idx : N-1-idx];
        end
        s_prev_sel = sel;
    end

    always @(negedge sys_clock) begin : monitor
        if (reset_n && mrx_data_valid) begin
            vcount++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid actual=1 expected=0 master_out=%h", master_out);
            end else begin
                e = sb.pop_front();
                chk("master_out",        32'(master_out), 32'(e.exp_out));
                chk("valid_latency",     cyc, e.exp_cyc);
                chk("ss_n_at_valid",     32'(ss_n), 32'hF);
                chk("tx_ready_at_valid", 32'(tx_ready), 32'd1);
                chk("mosi_word",         32'(s_cap), 32'(e.exp_mosi));
                chk("sclk_edges",        s_edges, 2*N);
                chk("sclk_rises",        s_rises, N);
                chk("ss_n_during",       32'({s_ss_bad, s_ss_seen}), 32'({1'b0, e.exp_ss}));
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge sys_clock);
        while (!(tx_ready && sb.size() == 0) && n < 3000) begin
            @(negedge sys_clock);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL wait_idle timeout tx_ready=%0b pending=%0d expected idle", tx_ready, sb.size());
        end
    endtask

    task automatic launch(input logic [N-1:0] d, input logic [SSW-1:0] sel, input logic [DW-1:0] div,
                          input logic [1:0] mode, input logic lsb, input logic [N-1:0] sw,
                          input logic echo, input logic [N-1:0] expo, input logic push);
        int  h;
        sb_t x;
        h = (div == 0) ? 1 : int'(div);
        wait_idle();
        s_word = sw; s_mode = mode; s_lsb = lsb; s_echo = echo;
        data_in = d; ss_sel = sel; clk_div = div; spi_mode = mode; lsb_first = lsb;
        tx_enable = 1'b1;
        if (push) begin
            x.exp_out  = expo;
            x.exp_mosi = d;
            x.exp_cyc  = cyc + (2*N+2)*h + 1;
            x.exp_ss   = ~(NSS'(1) << sel);
            sb.push_back(x);
        end
        @(negedge sys_clock);
        tx_enable = 1'b0;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [N-1:0]   d, w;
        logic [1:0]     md;
        logic [DW-1:0]  dv;
        logic [SSW-1:0] sl;
        logic           lb, ec, saw, sclk0;
        int             n, vc0;

        repeat (3) @(negedge sys_clock);
        chk("rst_ss_n",       32'(ss_n), 32'hF);
        chk("rst_mosi",       32'(mosi), 32'd1);
        chk("rst_sclk",       32'(sclk), 32'd0);
        chk("rst_master_out", 32'(master_out), 32'h3FFFF);
        chk("rst_valid",      32'(mrx_data_valid), 32'd0);
        chk("rst_tx_error",   32'(tx_error), 32'd0);
        reset_n = 1'b1;
        @(negedge sys_clock);
        chk("idle_tx_ready",  32'(tx_ready), 32'd1);

        // Mode0, H=2, LSB first, slave 1
        launch(18'h2A5A5, 3'd1, 8'd2, 2'd0, 1'b1, 18'h15A5A, 1'b0, 18'h15A5A, 1'b1);

        // Mode3, H=1, MSB first, echoing slave
        wait_idle();
        spi_mode = 2'd3;
        @(negedge sys_clock);
        chk("sclk_idle_cpol1", 32'(sclk), 32'd1);
        launch(18'h3FFFE, 3'd0, 8'd1, 2'd3, 1'b0, 18'h0, 1'b1, 18'h3FFFE, 1'b1);
        chk("mosi_first_bit", 32'(mosi), 32'd1);

        // Modes 1 and 2 with a single set bit
        w = N'($urandom);
        launch(18'h00001, 3'd2, 8'd3, 2'd1, 1'b0, w, 1'b0, w, 1'b1);
        w = N'($urandom);
        launch(18'h00001, 3'd3, 8'd2, 2'd2, 1'b1, w, 1'b0, w, 1'b1);

        // Out-of-range select
        wait_idle();
        spi_mode = 2'd0;
        @(negedge sys_clock);
        sclk0 = sclk;
        ss_sel = 3'd5;
        tx_enable = 1'b1;
        @(negedge sys_clock);
        tx_enable = 1'b0;
        chk("tx_error_pulse", 32'(tx_error), 32'd1);
        chk("err_tx_ready",   32'(tx_ready), 32'd1);
        chk("err_ss_n",       32'(ss_n), 32'hF);
        @(negedge sys_clock);
        chk("tx_error_clear", 32'(tx_error), 32'd0);
        repeat (4) @(negedge sys_clock);
        chk("err_idle_stable", 32'({sclk, tx_ready, ss_n}), 32'({sclk0, 1'b1, 4'hF}));

        // clk_div=0 behaves as H=1
        d = N'($urandom); w = N'($urandom);
        launch(d, 3'd0, 8'd0, 2'd0, 1'b0, w, 1'b0, w, 1'b1);

        // Request while busy is ignored without error
        d = N'($urandom); w = N'($urandom);
        launch(d, 3'd2, 8'd2, 2'd0, 1'b1, w, 1'b0, w, 1'b1);
        repeat (5) @(negedge sys_clock);
        saw = 1'b0;
        tx_enable = 1'b1; data_in = ~d; ss_sel = 3'd5;
        repeat (10) begin
            @(negedge sys_clock);
            saw = saw | tx_error | tx_ready;
        end
        tx_enable = 1'b0;
        chk("busy_req_ignored", 32'(saw), 32'd0);

        // Reset mid-transfer around edge 10
        d = N'($urandom); w = N'($urandom);
        launch(d, 3'd0, 8'd2, 2'd0, 1'b0, w, 1'b0, w, 1'b0);
        n = 0;
        while (s_edges < 10 && n < 500) begin
            @(negedge sys_clock);
            n++;
        end
        chk("abort_edge_reached", 32'(n < 500), 32'd1);
        vc0 = vcount;
        reset_n = 1'b0;
        #1;
        chk("abort_ss_n",       32'(ss_n), 32'hF);
        chk("abort_sclk",       32'(sclk), 32'd0);
        chk("abort_master_out", 32'(master_out), 32'h3FFFF);
        chk("abort_valid",      32'(mrx_data_valid), 32'd0);
        @(negedge sys_clock);
        reset_n = 1'b1;
        repeat (100) @(negedge sys_clock);
        chk("abort_no_valid", vcount, vc0);

        // Randomized transfers
        for (int i = 0; i < 10; i++) begin
            d  = N'($urandom);
            w  = N'($urandom);
            md = 2'($urandom_range(0, 3));
            dv = DW'($urandom_range(0, 3));
            lb = 1'($urandom_range(0, 1));
            sl = SSW'($urandom_range(0, NSS-1));
            ec = ($urandom_range(0, 3) == 0);
            launch(d, sl, dv, md, lb, w, ec, ec ? d : w, 1'b1);
        end

`ifdef SPI_LOOPBACK_EN
        wait_idle();
        loopback = 1'b1;
        s_force0 = 1'b1;
        launch(18'h12345, 3'd1, 8'd1, 2'd0, 1'b0, 18'h2AAAA, 1'b0, 18'h12345, 1'b1);
        wait_idle();
        loopback = 1'b0;
        s_force0 = 1'b0;
`endif

        wait_idle();
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_master_mc.md
Name: spi_master_mc

Overview:
Parametrised successor to the single-chip-select SPI master. A fully synchronous master: SCLK is generated from sys_clock by a runtime divider, every register is clocked by sys_clock only, and there is no edge-triggered logic on SCLK. It supports configurable word length, NUM_SS one-hot chip selects, all four SPI modes, and selectable bit order. It sits between the register/control logic and the SPI pads of the multi-slave subsystem.

Parameters:
DATA_W, 18, bits per transfer (2..32)
NUM_SS, 4, number of active-low slave selects (1..16)
SS_W, 2, width of ss_sel, at least clog2(NUM_SS)
DIV_W, 8, width of clk_div

Ports:
sys_clock  in  1  system clock; all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
tx_enable  in  1  request; a transfer is accepted on a cycle where tx_enable && tx_ready
tx_ready  out  1  high only in IDLE
data_in  in  DATA_W  transmit word, captured on acceptance
ss_sel  in  SS_W  target slave index, captured on acceptance
clk_div  in  DIV_W  SCLK half-period H in sys_clock cycles; 0 is treated as 1
spi_mode  in  2  [1]=CPOL, [0]=CPHA; captured on acceptance
lsb_first  in  1  1 = LSB first, 0 = MSB first; captured on acceptance
miso  in  1  serial data from slave
ss_n  out  NUM_SS  active-low selects; at most one bit low
mosi  out  1  serial data to slave
sclk  out  1  registered serial clock
master_out  out  DATA_W  last received word
mrx_data_valid  out  1  one-cycle pulse when master_out updates
tx_error  out  1  one-cycle pulse when a request is rejected

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, ss_n=all 1s, mosi=1, sclk=0.
  - master_out=all 1s, mrx_data_valid=0, tx_error=0.
  - Internal counters and shift registers are cleared.
- IDLE:
  - sclk is registered to the live spi_mode[1] every cycle. mosi=1.
  - On a valid request with ss_sel<NUM_SS, go to SETUP and capture all configuration and data.
  - If ss_sel>=NUM_SS, pulse tx_error for 1 cycle, start no transfer, and stay in IDLE.
- SETUP (H cycles):
  - ss_n[ss_sel]=0. mosi drives the first bit: data_in[0] if lsb_first, otherwise data_in[DATA_W-1].
  - sclk holds CPOL.
- TRANSFER (2*DATA_W*H cycles):
  - sclk toggles every H cycles, giving 2*DATA_W edges; it ends at CPOL.
  - CPHA=0: sample miso on odd (leading) edges; shift mosi on even (trailing) edges, except after the last edge.
  - CPHA=1: shift mosi on leading edges, except the first (bit 0 already driven); sample on trailing edges.
  - Received bits are assembled so that master_out is in the same bit order convention as data_in.
- HOLD (H cycles):
  - ss_n stays asserted and sclk=CPOL. Then go to IDLE.
  - In that same cycle: ss_n all 1s, master_out updated, mrx_data_valid pulses for 1 cycle.
- Latency: mrx_data_valid occurs (2*DATA_W+2)*H+1 cycles after the acceptance cycle. tx_ready returns in the same cycle as mrx_data_valid.
- tx_enable while not in IDLE is ignored, with no error. Changes to clk_div, spi_mode, lsb_first or ss_sel mid-transfer have no effect.
- Reset mid-transfer aborts immediately: ss_n all 1s, no mrx_data_valid, master_out returns to all 1s.
- Counters: an edge counter of clog2(2*DATA_W+1) bits and a divider counter of DIV_W bits. Neither wraps: they stop at terminal count.

Optional Feature:
SPI_LOOPBACK_EN
- Defined: adds input port loopback (1 bit). When loopback=1, captured at acceptance, the sample path takes the internal mosi instead of miso, so master_out equals data_in. Pad miso is ignored. sclk and ss_n behave normally.
- Undefined: the port is absent and the sample path always uses miso.

Test Plan:
- Mode0, H=2, lsb_first=1, ss_sel=1, data_in=0x2A5A5; slave model returns 0x15A5A -> ss_n=4'b1101 during the transfer; 18 rising sclk edges; master_out=0x15A5A; mrx_data_valid pulses exactly 77 cycles after acceptance; ss_n=4'hF in the same cycle.
- Mode3, H=1, lsb_first=0, data_in=0x3FFFE; slave model echoes mosi -> sclk idles high; first mosi bit=1; last bit=0; master_out=0x3FFFE.
- Modes 1 and 2 with data_in=0x00001 -> sampling and shift edges match the CPHA rule; master_out matches slave data in both modes.
- ss_sel=5 with NUM_SS=4 -> tx_error 1-cycle pulse, ss_n stays 4'hF, tx_ready stays 1, no sclk activity. Then clk_div=0 with a valid request -> behaves as H=1.
- Assert tx_enable again mid-transfer -> ignored and the second word is never sent. Assert reset_n=0 at edge 10 -> ss_n=4'hF, sclk=0, master_out=0x3FFFF, no valid pulse.
- SPI_LOOPBACK_EN defined, loopback=1, miso tied to 0, data_in=0x12345 -> master_out=0x12345.
